// File: rtl/attack_mobility_eval.sv
// ---------------------------------------------------------------------------
// attack_mobility_eval
//
// Turns the attack maps and check flags from board_attack into a signed
// mobility term. On a rising edge of is_attacking_done the two 64-bit maps
// and the check flags are snapshotted. The maps are then popcounted one byte
// (one board row) per cycle over 8 cycles. A scaled, saturated score is
// formed and presented to the evaluator with a valid/ack handshake. Once the
// score is accepted, clear_attack is pulsed back upstream.
//
// Ports
//   clk                 single clock, all logic on posedge
//   reset               asynchronous, active-high, clears all state
//   is_attacking_done   level from board_attack; maps and flags valid while high
//   white_is_attacking  squares attacked by white, bit = row<<3|col
//   black_is_attacking  squares attacked by black, bit = row<<3|col
//   white_in_check      white king attacked
//   black_in_check      black king attacked
//   score_ack           consumer accepts mobility_score (only while valid)
//   clear_attack        one-cycle pulse after the score is accepted
//   busy                high in any state other than IDLE
//   mobility_valid      score and counts are stable and valid
//   mobility_score      signed score, positive favours white
//   white_attack_count  squares attacked by white, 0..64
//   black_attack_count  squares attacked by black, 0..64
// ---------------------------------------------------------------------------
module attack_mobility_eval #(
    parameter int unsigned MOBILITY_WEIGHT = 4,
    parameter int unsigned CHECK_PENALTY   = 50,
    parameter int unsigned SCORE_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          is_attacking_done,
    input  logic [63:0]                   white_is_attacking,
    input  logic [63:0]                   black_is_attacking,
    input  logic                          white_in_check,
    input  logic                          black_in_check,
    input  logic                          score_ack,
    output logic                          clear_attack,
    output logic                          busy,
    output logic                          mobility_valid,
    output logic signed [SCORE_WIDTH-1:0] mobility_score,
    output logic [6:0]                    white_attack_count,
    output logic [6:0]                    black_attack_count
);

    // The score is formed with 8 extra bits of headroom before saturation.
    localparam int EW = SCORE_WIDTH + 8;
    localparam logic signed [EW-1:0] WEIGHT_S  = EW'(MOBILITY_WEIGHT);
    localparam logic signed [EW-1:0] PENALTY_S = EW'(CHECK_PENALTY);
    localparam logic signed [EW-1:0] SAT_MAX   = EW'((longint'(1) << (SCORE_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN   = -SAT_MAX - EW'(1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SCALE,
        DONE
    } state_t;

    state_t state, state_next;

    logic        done_q;
    logic        done_rise;
    logic [63:0] white_snap, black_snap;
    logic        wic_snap, bic_snap;
    logic [6:0]  acc_w, acc_b;
    logic [2:0]  row;

    logic signed [EW-1:0]          diff;
    logic signed [EW-1:0]          raw_score;
    logic signed [SCORE_WIDTH-1:0] sat_score;

    function automatic logic [6:0] popcount8(input logic [7:0] b);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 7'(b[i]);
        end
        return n;
    endfunction

    // Only a rising edge starts work, so a level held high is counted once.
    assign done_rise = is_attacking_done & ~done_q;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values, independent of block ordering.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so every path drives state_next; a
        // missing branch would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (done_rise) state_next = COUNT;
            COUNT:   if (row == 3'd7) state_next = SCALE;
            SCALE:   state_next = DONE;
            DONE:    if (score_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Weighted difference plus check adjustments, then clamp to the output range.
    always_comb begin
        diff      = EW'(signed'({1'b0, acc_w})) - EW'(signed'({1'b0, acc_b}));
        raw_score = WEIGHT_S * diff;
        if (wic_snap) raw_score = raw_score - PENALTY_S;
        if (bic_snap) raw_score = raw_score + PENALTY_S;
        if (raw_score > SAT_MAX) begin
            sat_score = SCORE_WIDTH'(SAT_MAX);
        end else if (raw_score < SAT_MIN) begin
            sat_score = SCORE_WIDTH'(SAT_MIN);
        end else begin
            sat_score = SCORE_WIDTH'(raw_score);
        end
    end

    // Datapath: snapshot, serial popcount, result registers, handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the snapshot registers are reset along with the control
            // state, so no stale map can leak into a result after reset.
            done_q             <= 1'b0;
            white_snap         <= '0;
            black_snap         <= '0;
            wic_snap           <= 1'b0;
            bic_snap           <= 1'b0;
            acc_w              <= '0;
            acc_b              <= '0;
            row                <= '0;
            clear_attack       <= 1'b0;
            mobility_valid     <= 1'b0;
            mobility_score     <= '0;
            white_attack_count <= '0;
            black_attack_count <= '0;
        end else begin
            done_q       <= is_attacking_done;
            clear_attack <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        white_snap <= white_is_attacking;
                        black_snap <= black_is_attacking;
                        wic_snap   <= white_in_check;
                        bic_snap   <= black_in_check;
                        acc_w      <= '0;
                        acc_b      <= '0;
                        row        <= '0;
                    end
                end
                COUNT: begin
                    acc_w <= acc_w + popcount8(white_snap[{row, 3'b000} +: 8]);
                    acc_b <= acc_b + popcount8(black_snap[{row, 3'b000} +: 8]);
                    row   <= row + 3'd1;
                end
                SCALE: begin
                    white_attack_count <= acc_w;
                    black_attack_count <= acc_b;
                    mobility_score     <= sat_score;
                    mobility_valid     <= 1'b1;
                end
                DONE: begin
                    // Valid was already high at this edge, so ack here is a true accept.
                    if (score_ack) begin
                        mobility_valid <= 1'b0;
                        clear_attack   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
